// File: rtl/icache_refill_arbiter.sv
// icache_refill_arbiter
//
// Shares the single 128-bit-line backing memory between instruction-cache and
// data-cache misses. It accepts one line request at a time. It holds the
// line-aligned address on the memory port for MEM_LAT cycles and captures the
// returned line. It then signals the requester with a one-cycle valid pulse.
// While a refill is pending, or while any miss request is raised, it holds the
// pipeline stall.
//
// Optional feature macro: ROUND_ROBIN_EN
//   defined   - a contended IDLE cycle grants the requester that was not served last
//   undefined - fixed priority, the data cache always wins
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   i_req, i_addr      instruction miss request (level) and word address
//   d_req, d_addr      data miss request (level) and word address
//   i_gnt, d_gnt       one-cycle pulse in the first memory cycle of the winner
//   i_valid, d_valid   one-cycle pulse while line_out holds the requested line
//   line_out           registered refill line, held until the next capture
//   mem_addr, mem_rd   line-aligned memory address and read strobe
//   mem_rdata          memory line data, valid while mem_rd is high
//   stall              pipeline stall

module icache_refill_arbiter #(
   parameter int unsigned ADDR_W  = 30,
   parameter int unsigned LINE_W  = 128,
   parameter int unsigned MEM_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              i_gnt,
   output logic              d_gnt,
   output logic              i_valid,
   output logic              d_valid,
   output logic [LINE_W-1:0] line_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              stall
);

   localparam int unsigned CntW = $clog2(MEM_LAT + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-3:0]   addr_q;   // line address; the word offset is never sent to memory
   logic                sel_d_q;  // 1: the current refill belongs to the data cache
   logic [CntW-1:0]     cnt_q;
   logic [LINE_W-1:0]   line_q;
   logic                any_req;
   logic                pick_d;

   // The word offset selects a word inside line_out on the requester side only.
   logic unused_word_offset;
   assign unused_word_offset = ^{i_addr[1:0], d_addr[1:0]};

   assign any_req = i_req | d_req;

`ifdef ROUND_ROBIN_EN
   logic last_d_q;  // 1: the data cache was granted most recently

   // A single request always wins. On contention the pointer decides.
   assign pick_d = d_req & (~i_req | ~last_d_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_d_q <= 1'b1;
      end else if (state_q == StIdle && any_req) begin
         last_d_q <= pick_d;
      end
   end
`else
   assign pick_d = d_req;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_req) state_d = StBusy;
         StBusy:  if (cnt_q == '0) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Request latch, access counter and line capture
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         sel_d_q <= 1'b0;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         if (state_q == StIdle && any_req) begin
            addr_q  <= pick_d ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
            sel_d_q <= pick_d;
            cnt_q   <= CntLoad;
         end else if (state_q == StBusy) begin
            if (cnt_q == '0) begin
               line_q <= mem_rdata;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end

   // Outputs
   always_comb begin
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_valid  = 1'b0;
      d_valid  = 1'b0;
      mem_rd   = 1'b0;
      mem_addr = '0;
      unique case (state_q)
         StBusy: begin
            mem_rd   = 1'b1;
            mem_addr = {addr_q, 2'b00};
            // The counter still holds its load value only in the first memory cycle.
            i_gnt    = (cnt_q == CntLoad) & ~sel_d_q;
            d_gnt    = (cnt_q == CntLoad) & sel_d_q;
         end
         StDone: begin
            i_valid = ~sel_d_q;
            d_valid = sel_d_q;
         end
         default: ;
      endcase
   end

   assign stall    = (state_q != StIdle) | any_req;
   assign line_out = line_q;

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Bench for icache_refill_arbiter. Two instances, with MEM_LAT=3 and
// MEM_LAT=1, receive the same stimulus. A timeline model for each
// instance tracks the cycles elapsed since acceptance and predicts every
// output on every cycle. Directed sequences with literal expectations come
// before a randomized phase.

module tb_icache_refill_arbiter;

   localparam int unsigned AW = 30;
   localparam int unsigned LW = 128;

`ifdef ROUND_ROBIN_EN
   localparam bit RoundRobin = 1'b1;
`else
   localparam bit RoundRobin = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0;
   logic          d_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [AW-1:0] d_addr = '0;
   logic [LW-1:0] mem_rdata = '0;

   logic [1:0]    i_gnt_w, d_gnt_w, i_valid_w, d_valid_w, mem_rd_w, stall_w;
   logic [LW-1:0] line_w [2];
   logic [AW-1:0] maddr_w [2];

   always #5 clk = ~clk;

   icache_refill_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
      .i_gnt(i_gnt_w[0]), .d_gnt(d_gnt_w[0]), .i_valid(i_valid_w[0]), .d_valid(d_valid_w[0]),
      .line_out(line_w[0]), .mem_addr(maddr_w[0]), .mem_rd(mem_rd_w[0]),
      .mem_rdata(mem_rdata), .stall(stall_w[0])
   );

   icache_refill_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
      .i_gnt(i_gnt_w[1]), .d_gnt(d_gnt_w[1]), .i_valid(i_valid_w[1]), .d_valid(d_valid_w[1]),
      .line_out(line_w[1]), .mem_addr(maddr_w[1]), .mem_rd(mem_rd_w[1]),
      .mem_rdata(mem_rdata), .stall(stall_w[1])
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Model: ph = 0 when idle, otherwise the number of cycles since acceptance.
   // 1..lat is the memory phase and lat+1 the valid cycle.
   int            lat [2] = '{3, 1};
   int            ph [2];
   bit            win_d [2];
   bit            last_d [2];
   logic [AW-1:0] m_addr [2];
   logic [LW-1:0] m_line [2];
   bit            model_on = 1'b0;

   // Advance the model over the clock edge just taken. Inputs still hold the
   // values the DUT sampled.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            ph[k] = 0; m_line[k] = '0; last_d[k] = 1'b1; win_d[k] = 1'b0; m_addr[k] = '0;
         end else if (ph[k] == 0) begin
            if (i_req || d_req) begin
               if (i_req && d_req) win_d[k] = RoundRobin ? !last_d[k] : 1'b1;
               else                win_d[k] = d_req;
               last_d[k] = win_d[k];
               m_addr[k] = (win_d[k] ? d_addr : i_addr) & ~30'h3;
               ph[k] = 1;
            end
         end else if (ph[k] <= lat[k]) begin
            if (ph[k] == lat[k]) m_line[k] = mem_rdata;
            ph[k]++;
         end else begin
            ph[k] = 0;
         end
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (model_on) begin
         for (int k = 0; k < 2; k++) begin
            bit g, v, r;
            g = (ph[k] == 1);
            r = (ph[k] >= 1 && ph[k] <= lat[k]);
            v = (ph[k] == lat[k] + 1);
            chk($sformatf("i_gnt/lat%0d", lat[k]), LW'(i_gnt_w[k]), LW'(g & !win_d[k]));
            chk($sformatf("d_gnt/lat%0d", lat[k]), LW'(d_gnt_w[k]), LW'(g & win_d[k]));
            chk($sformatf("i_valid/lat%0d", lat[k]), LW'(i_valid_w[k]), LW'(v & !win_d[k]));
            chk($sformatf("d_valid/lat%0d", lat[k]), LW'(d_valid_w[k]), LW'(v & win_d[k]));
            chk($sformatf("mem_rd/lat%0d", lat[k]), LW'(mem_rd_w[k]), LW'(r));
            chk($sformatf("mem_addr/lat%0d", lat[k]), LW'(maddr_w[k]), LW'(r ? m_addr[k] : '0));
            chk($sformatf("line_out/lat%0d", lat[k]), line_w[k], m_line[k]);
            chk($sformatf("stall/lat%0d", lat[k]), LW'(stall_w[k]),
                LW'(ph[k] != 0 || i_req || d_req));
         end
      end
   end

   // One cycle: take the edge, update the model, apply the new inputs, and settle.
   task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic [AW-1:0] da, input logic [LW-1:0] rd);
      @(posedge clk);
      #1;
      model_step();
      model_on = 1'b1;
      rst = r; i_req = ir; i_addr = ia; d_req = dr; d_addr = da; mem_rdata = rd;
      #1;
   endtask

   localparam logic [LW-1:0] K1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
   localparam logic [LW-1:0] K2 = 128'hdead_beef_cafe_f00d_1111_2222_3333_4444;
   localparam bit FirstD = !RoundRobin;  // reset pointer "data" lets i win under round robin

   initial begin
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, K1);
      chk("reset line_out", line_w[0], '0);
      chk("reset stall", LW'(stall_w[0]), '0);

      // Single instruction miss
      step(0, 1, 30'h13, 0, 0, K1);                                        // c0
      chk("c0 stall", LW'(stall_w[0]), 1);
      chk("c0 i_gnt", LW'(i_gnt_w[0]), 0);
      step(0, 0, 0, 0, 0, K1);                                             // c1
      chk("c1 i_gnt", LW'(i_gnt_w[0]), 1);
      chk("c1 mem_addr", LW'(maddr_w[0]), LW'(30'h10));
      chk("c1 mem_rd lat1", LW'(mem_rd_w[1]), 1);
      step(0, 0, 0, 0, 0, K1);                                             // c2
      chk("c2 i_gnt", LW'(i_gnt_w[0]), 0);
      chk("c2 i_valid lat1", LW'(i_valid_w[1]), 1);
      chk("c2 line_out lat1", line_w[1], K1);
      chk("c2 mem_rd lat1", LW'(mem_rd_w[1]), 0);
      step(0, 0, 0, 0, 0, K1);                                             // c3
      chk("c3 mem_rd", LW'(mem_rd_w[0]), 1);
      chk("c3 stall lat1", LW'(stall_w[1]), 0);
      step(0, 0, 0, 0, 0, 0);                                              // c4
      chk("c4 i_valid", LW'(i_valid_w[0]), 1);
      chk("c4 line_out", line_w[0], K1);
      chk("c4 mem_rd", LW'(mem_rd_w[0]), 0);
      chk("c4 stall", LW'(stall_w[0]), 1);
      step(0, 0, 0, 0, 0, 0);                                              // c5
      chk("c5 stall", LW'(stall_w[0]), 0);

      // Simultaneous miss (after reset so the pointer is "data")
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c <= 10; c++) begin
         logic fr, sr;
         fr = (c <= 3);
         sr = (c <= 8);
         step(0, FirstD ? sr : fr, 30'h20, FirstD ? fr : sr, 30'h44, K2);
         if (c == 1) begin
            chk("both c1 first gnt", LW'(FirstD ? d_gnt_w[0] : i_gnt_w[0]), 1);
            chk("both c1 mem_addr", LW'(maddr_w[0]), LW'(FirstD ? 30'h44 : 30'h20));
         end
         if (c == 4) chk("both c4 first valid", LW'(FirstD ? d_valid_w[0] : i_valid_w[0]), 1);
         if (c == 5) chk("both c5 stall", LW'(stall_w[0]), 1);
         if (c == 6) begin
            chk("both c6 second gnt", LW'(FirstD ? i_gnt_w[0] : d_gnt_w[0]), 1);
            chk("both c6 mem_addr", LW'(maddr_w[0]), LW'(FirstD ? 30'h20 : 30'h44));
         end
         if (c == 9) chk("both c9 second valid", LW'(FirstD ? i_valid_w[0] : d_valid_w[0]), 1);
      end

      // Reset in the middle of a data refill
      step(0, 0, 0, 1, 30'h100, K1);                                       // c0
      step(0, 0, 0, 1, 30'h100, K1);                                       // c1
      step(1, 0, 0, 0, 0, K1);                                             // c2
      step(0, 0, 0, 0, 0, K1);                                             // c3
      chk("rst c3 mem_rd", LW'(mem_rd_w[0]), 0);
      chk("rst c3 mem_addr", LW'(maddr_w[0]), 0);
      chk("rst c3 line_out", line_w[0], 0);
      chk("rst c3 stall", LW'(stall_w[0]), 0);
      for (int c = 4; c <= 6; c++) begin
         step(0, 0, 0, 0, 0, K1);
         chk("rst no d_valid", LW'(d_valid_w[0]), 0);
      end
      step(0, 0, 0, 1, 30'h104, K2);                                       // restart c0
      step(0, 0, 0, 0, 0, K2);
      chk("restart c1 d_gnt", LW'(d_gnt_w[0]), 1);
      step(0, 0, 0, 0, 0, K2);
      step(0, 0, 0, 0, 0, K2);
      step(0, 0, 0, 0, 0, K2);
      chk("restart c4 d_valid", LW'(d_valid_w[0]), 1);
      chk("restart c4 line_out", line_w[0], K2);
      step(0, 0, 0, 0, 0, 0);

      // Late instruction request during a data refill
      for (int c = 0; c <= 9; c++) begin
         step(0, (c >= 2 && c <= 7), 30'h2c, (c == 0), 30'h80, K1);
         chk("late stall", LW'(stall_w[0]), 1);
         if (c == 5) chk("late c5 i_gnt", LW'(i_gnt_w[0]), 0);
         if (c == 6) chk("late c6 i_gnt", LW'(i_gnt_w[0]), 1);
      end
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Randomized phase
      for (int n = 0; n < 4000; n++) begin
         step($urandom_range(99) == 0, $urandom_range(9) < 4, AW'($urandom),
              $urandom_range(9) < 4, AW'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
      end

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
